// File: rtl/ripple_count_reader.sv
// Samples an asynchronous ripple counter into clk, filters ripple glitches and serves count/delta/wrap reads.
// Optional WAIT timeout enabled by defining RIPPLE_READER_TIMEOUT_EN.
module ripple_count_reader #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_down,
  input  logic             rd_req,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_value,
  output logic [WIDTH-1:0] rd_delta,
  output logic             rd_wrap,
  output logic             rd_timeout
);

  localparam int SW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  if (WIDTH < 2 || STABLE_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("ripple_count_reader: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] s1, s2, s2_prev, last;
  logic             dir1, dir2;
  logic [SW-1:0]    stab_cnt;
  logic             stable;
  logic             timeout_hit;
  logic             capture, capture_to;
  logic [WIDTH-1:0] delta_cap;
  logic             wrap_cap;

  // Each bit is synchronized on its own; incoherent mid-ripple samples never
  // survive the stability filter because they change again next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s2_prev  <= '0;
      dir1     <= 1'b0;
      dir2     <= 1'b0;
      stab_cnt <= '0;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      s2_prev <= s2;
      dir1    <= cnt_down;
      dir2    <= dir1;
      if (s2 != s2_prev)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + SW'(1);
    end
  end

  assign stable    = (stab_cnt == STAB_MAX);
  assign delta_cap = dir2 ? (last - s2) : (s2 - last);
  assign wrap_cap  = dir2 ? (s2 > last) : (s2 < last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    capture_to = 1'b0;
    case (state)
      IDLE: if (rd_req) state_nxt = WAIT;
      WAIT: begin
        if (stable) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else if (timeout_hit) begin
          state_nxt  = RESP;
          capture_to = 1'b1;
        end
      end
      RESP: if (rd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_value <= '0;
      rd_delta <= '0;
      rd_wrap  <= 1'b0;
      last     <= '0;
    end else if (capture) begin
      rd_value <= s2;
      rd_delta <= delta_cap;
      rd_wrap  <= wrap_cap;
      last     <= s2;
    end else if (capture_to) begin
      // Timeout response reports the raw sample but leaves last untouched.
      rd_value <= s2;
      rd_delta <= '0;
      rd_wrap  <= 1'b0;
    end
  end

`ifdef RIPPLE_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [TW-1:0] wait_cnt;
  logic          timeout_r;

  // Preloaded to 1 while idle so wait_cnt equals the number of WAIT cycles spent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (state == IDLE)
      wait_cnt <= TW'(1);
    else if (state == WAIT && wait_cnt != TO_MAX)
      wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           timeout_r <= 1'b0;
    else if (capture)    timeout_r <= 1'b0;
    else if (capture_to) timeout_r <= 1'b1;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == TO_MAX);
  assign rd_timeout  = timeout_r;
`else
  assign timeout_hit = 1'b0;
  assign rd_timeout  = 1'b0;
`endif

endmodule
